multicycle_control_fsm: RTL and testbench

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for a multicycle RV32I datapath: Moore state machine producing
// datapath selects and write enables, plus the branch-taken and immediate-format decode.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       ALUb31,
    input  logic       Cout,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       JALR_LSB,
    output logic [2:0] ImmSrc,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_JALRADR  = 4'd14
    } state_t;

    state_t state_q, state_d;
    logic   pc_update, branch, taken;
    logic   ir_write_raw, mem_write_raw, reg_write_raw;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d       = S_FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        JALR_LSB      = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_update    = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALRADR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_JAL, S_JALR: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALRADR: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                JALR_LSB = 1'b1;
                state_d  = S_JALR;
            end
            S_LUI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 2'b11;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = ALUb31;
            3'b101:  taken = !ALUb31;
            3'b110:  taken = !Cout;
            3'b111:  taken = Cout;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:        ImmSrc = 3'b001;
            OP_BRANCH:       ImmSrc = 3'b010;
            OP_JAL:          ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:         ImmSrc = 3'b000;
        endcase
    end

    // Enables are held off for the whole reset pulse, not just until the state flop clears.
    assign PCWrite  = !reset && (pc_update || (branch && taken));
    assign IRWrite  = !reset && ir_write_raw;
    assign MemWrite = !reset && mem_write_raw;
    assign RegWrite = !reset && reg_write_raw;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed scenarios plus random
// instruction streams compared against an instruction-level reference model.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero, ALUb31, Cout;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, JALR_LSB;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] state;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       jalr_lsb;
    } ctrl_t;

    ctrl_t act;
    assign act = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUOp, JALR_LSB};

    int n_checks = 0;
    int n_errors = 0;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .Zero(Zero), .ALUb31(ALUb31), .Cout(Cout),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .JALR_LSB(JALR_LSB), .ImmSrc(ImmSrc), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // State trajectory of one instruction, FETCH first; -1 once the instruction is done.
    function automatic int ref_path(input logic [6:0] o, input int k);
        int p[$];
        case (o)
            7'b0000011: p = {0, 1, 2, 3, 4};
            7'b0100011: p = {0, 1, 2, 5};
            7'b0110011: p = {0, 1, 6, 7};
            7'b0010011: p = {0, 1, 8, 7};
            7'b1101111: p = {0, 1, 9, 7};
            7'b1100111: p = {0, 1, 14, 11, 7};
            7'b1100011: p = {0, 1, 10};
            7'b0110111: p = {0, 1, 12, 7};
            7'b0010111: p = {0, 1, 13, 7};
            default:    p = {0, 1};
        endcase
        if (k >= p.size()) return -1;
        return p[k];
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic n, input logic c);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return n;
            3'b101:  return !n;
            3'b110:  return !c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t ref_ctrl(input int s, input logic [2:0] f3, input logic z,
                                       input logic n, input logic c, input bit in_rst);
        ctrl_t e = '0;
        case (s)
            0:  begin e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2; e.result_src = 2; end
            1:  begin e.alu_src_a = 1; e.alu_src_b = 1; end
            2:  begin e.alu_src_a = 2; e.alu_src_b = 1; end
            3:  e.adr_src = 1;
            4:  begin e.result_src = 1; e.reg_write = 1; end
            5:  begin e.adr_src = 1; e.mem_write = 1; end
            6:  begin e.alu_src_a = 2; e.alu_op = 2; end
            7:  e.reg_write = 1;
            8:  begin e.alu_src_a = 2; e.alu_src_b = 1; e.alu_op = 2; end
            9, 11: begin e.alu_src_a = 1; e.alu_src_b = 2; e.pc_write = 1; end
            10: begin e.alu_src_a = 2; e.alu_op = 1; e.pc_write = ref_taken(f3, z, n, c); end
            12: begin e.alu_src_b = 1; e.alu_op = 3; end
            13: begin e.alu_src_a = 1; e.alu_src_b = 1; end
            14: begin e.alu_src_a = 2; e.alu_src_b = 1; e.jalr_lsb = 1; end
            default: e = '0;
        endcase
        if (in_rst) begin
            e.pc_write = 0; e.ir_write = 0; e.mem_write = 0; e.reg_write = 0;
        end
        return e;
    endfunction

    function automatic logic [2:0] ref_imm(input logic [6:0] o);
        case (o)
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b1101111:             return 3'd3;
            7'b0110111, 7'b0010111: return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    task automatic check_cycle(input int exp_state, input bit in_rst, input string tag);
        ctrl_t e;
        e = ref_ctrl(exp_state, funct3, Zero, ALUb31, Cout, in_rst);
        check({tag, ".state"}, 32'(state), 32'(exp_state));
        check({tag, ".ctrl"}, 32'(act), 32'(e));
        check({tag, ".imm"}, 32'(ImmSrc), 32'(ref_imm(op)));
    endtask

    // Walks up to max_k cycles of one instruction starting in FETCH, checking every cycle.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input bit rnd_flags,
                             input logic [2:0] flags, input int max_k, input string tag);
        op     = o;
        funct3 = f3;
        for (int k = 0; k < max_k && ref_path(o, k) >= 0; k++) begin
            if (rnd_flags) {Zero, ALUb31, Cout} = 3'($urandom);
            else           {Zero, ALUb31, Cout} = flags;
            #1;
            check_cycle(ref_path(o, k), 1'b0, tag);
            @(posedge clk);
            #1;
        end
    endtask

    logic [6:0] valid_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                                  7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};

    initial begin
        reset  = 1'b1;
        op     = 7'b0000000;
        funct3 = 3'b000;
        {Zero, ALUb31, Cout} = 3'b000;
        @(posedge clk);
        #1;
        check_cycle(0, 1'b1, "por");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_cycle(0, 1'b0, "por_release");

        // Load interrupted in MEMREAD by an asynchronous reset pulse
        run_instr(7'b0000011, 3'b010, 1'b1, 3'b000, 3, "ld_part");
        #1;
        check_cycle(3, 1'b0, "ld_memread");
        #2;
        reset = 1'b1;
        #1;
        check_cycle(0, 1'b1, "rst_async");
        @(posedge clk);
        #1;
        check_cycle(0, 1'b1, "rst_hold");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_cycle(0, 1'b0, "rst_release");

        run_instr(7'b0000011, 3'b010, 1'b1, 3'b000, 99, "load");
        run_instr(7'b1100011, 3'b110, 1'b0, 3'b000, 99, "bltu_cout0");
        run_instr(7'b1100011, 3'b110, 1'b0, 3'b001, 99, "bltu_cout1");
        run_instr(7'b1100011, 3'b010, 1'b0, 3'b111, 99, "br_f010_ones");
        run_instr(7'b1100011, 3'b010, 1'b0, 3'b000, 99, "br_f010_zeros");
        run_instr(7'b1100011, 3'b000, 1'b0, 3'b100, 99, "beq_z1");
        run_instr(7'b1100011, 3'b101, 1'b0, 3'b010, 99, "bge_n1");
        run_instr(7'b1100111, 3'b000, 1'b1, 3'b000, 99, "jalr");
        run_instr(7'b0000000, 3'b000, 1'b1, 3'b000, 99, "undef");
        run_instr(7'b0110111, 3'b000, 1'b1, 3'b000, 99, "lui");
        run_instr(7'b0100011, 3'b010, 1'b1, 3'b000, 99, "store");

        for (int i = 0; i < 60; i++) begin
            logic [6:0] o;
            if ($urandom_range(0, 3) == 0) o = 7'($urandom);
            else                           o = valid_ops[$urandom_range(0, 8)];
            run_instr(o, 3'($urandom), 1'b1, 3'b000, 99, "rand");
        end
        #1;
        check_cycle(0, 1'b0, "end_fetch");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
